// File: rtl/dmem_arbiter_if.sv
// Port bundle for dmem_arbiter: two requester channels, the MEM-stage stall
// and the variable-latency memory bus.
//
// Handshake: a requester raises req with we/addr/wdata/be stable and keeps them
// until its one-cycle ready pulse; rdata/fault are meaningful only with ready.
// On the memory side mem_req stays high with stable fields until the memory
// pulses mem_ack or mem_err (mem_err wins when both are high); mem_rdata is
// sampled together with mem_ack.
//
// slave  : the arbiter's view (serves the requesters, drives the memory bus).
// master : the environment's view (requesters plus memory model).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [BE_W-1:0]   m0_be;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_fault;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [BE_W-1:0]   m1_be;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_fault;

  logic              stall_m;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic              mem_err;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m0_ready, m0_rdata, m0_fault,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_ready, m1_rdata, m1_fault,
    output stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_err, mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m0_ready, m0_rdata, m0_fault,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_ready, m1_rdata, m1_fault,
    input  stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_err, mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single data-memory port.
// IDLE picks a requester (round-robin on contention), ACCESS holds the memory
// request until ack/err or the access timeout, RESP pulses the winner's ready.
// dbg_state exposes the FSM state: 0 = IDLE, 1 = ACCESS, 2 = RESP.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          start,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic              any_req;
  logic              grant_sel;
  logic              grant_fire;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  logic              access_done;
  logic              resp_fault;
  logic [DATA_W-1:0] resp_rdata;

  // Arbitration: a sole requester always wins; on contention the master that
  // was not served last wins, so a waiting master is never passed over twice.
  always_comb begin
    any_req    = bus.m0_req | bus.m1_req;
    grant_sel  = (bus.m0_req & bus.m1_req) ? ~last_grant : bus.m1_req;
    grant_fire = (state == S_IDLE) & any_req;
    sel_we     = grant_sel ? bus.m1_we    : bus.m0_we;
    sel_addr   = grant_sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata  = grant_sel ? bus.m1_wdata : bus.m0_wdata;
    sel_be     = grant_sel ? bus.m1_be    : bus.m0_be;
  end

  // Completion decode: err outranks ack; without either, the last allowed
  // ACCESS cycle ends the access as a fault. Stores and faults return zero data.
  always_comb begin
    access_done = (state == S_ACCESS) &
                  (bus.mem_ack | bus.mem_err | (cnt == CNT_LAST));
    resp_fault  = bus.mem_err | ~bus.mem_ack;
    resp_rdata  = (resp_fault | bus.mem_we) ? '0 : bus.mem_rdata;
  end

  // FSM, round-robin pointer and saturating ACCESS-cycle counter.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            state      <= S_ACCESS;
            last_grant <= grant_sel;
            cnt        <= '0;
          end
        end
        S_ACCESS: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          if (access_done) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory bus registers: fields latched at grant and held; mem_req spans ACCESS.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else if (grant_fire) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= sel_we;
      bus.mem_addr  <= sel_addr;
      bus.mem_wdata <= sel_wdata;
      bus.mem_be    <= sel_be;
    end else if (access_done) begin
      bus.mem_req   <= 1'b0;
    end
  end

  // Response registers: zero except in RESP, where only the granted master
  // sees ready with its rdata/fault.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      bus.m0_ready <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m0_fault <= 1'b0;
      bus.m1_ready <= 1'b0;
      bus.m1_rdata <= '0;
      bus.m1_fault <= 1'b0;
    end else begin
      bus.m0_ready <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m0_fault <= 1'b0;
      bus.m1_ready <= 1'b0;
      bus.m1_rdata <= '0;
      bus.m1_fault <= 1'b0;
      if (access_done) begin
        if (last_grant) begin
          bus.m1_ready <= 1'b1;
          bus.m1_rdata <= resp_rdata;
          bus.m1_fault <= resp_fault;
        end else begin
          bus.m0_ready <= 1'b1;
          bus.m0_rdata <= resp_rdata;
          bus.m0_fault <= resp_fault;
        end
      end
    end
  end

  assign bus.stall_m = bus.m0_req & ~bus.m0_ready;
  assign dbg_state   = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (built with TIMEOUT = 4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dmem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int TIMEOUT = 4;

  logic       clk;
  logic       start;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .start     (start),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_m0(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
  endtask

  task automatic drive_mem(input logic ack, input logic err, input logic [DATA_W-1:0] rdata);
    bus.mem_ack = ack; bus.mem_err = err; bus.mem_rdata = rdata;
  endtask

  task automatic clear_inputs();
    drive_m0(1'b0, 1'b0, '0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, '0);
    drive_mem(1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    clear_inputs();
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.m0_ready, bus.m1_ready, bus.m0_fault, bus.m1_fault, bus.mem_req, bus.mem_we} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {bus.m0_ready, bus.m1_ready, bus.m0_fault, bus.m1_fault, bus.mem_req, bus.mem_we});
    else n_pass++;
    n_checks++;
    if ({bus.m0_rdata, bus.m1_rdata} !== '0)
      $display("FAIL reset_rdata: got %h %h want 0 0", bus.m0_rdata, bus.m1_rdata);
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0)
      $display("FAIL reset_mem_fields: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
    else n_pass++;
    n_checks++;
    if (bus.stall_m !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall_m);
    else n_pass++;
    // a request held during reset must not reach the memory bus
    drive_m0(1'b1, 1'b0, 32'h40, '0, 4'hF);
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0) $display("FAIL reset_hold: mem_req got %b want 0", bus.mem_req);
    else n_pass++;
    clear_inputs();
    start = 1'b1;
  endtask

  task automatic test_single_load();
    int acc_k, stall_cnt, ready_cyc, ready_cnt, m1_cnt;
    logic ack;
    acc_k = 0; stall_cnt = 0; ready_cyc = -1; ready_cnt = 0; m1_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.m1_ready) m1_cnt++;
      if (bus.m0_ready) begin
        ready_cnt++;
        if (ready_cyc < 0) ready_cyc = cyc;
        n_checks++;
        if ({bus.m0_fault, bus.m0_rdata} !== {1'b0, 32'hDEADBEEF})
          $display("FAIL load_resp: fault=%b rdata=%h want 0 deadbeef", bus.m0_fault, bus.m0_rdata);
        else n_pass++;
      end
      if (bus.mem_req) begin
        acc_k++;
        if (acc_k == 1) begin
          n_checks++;
          if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h100})
            $display("FAIL load_bus: we=%b addr=%h want 0 100", bus.mem_we, bus.mem_addr);
          else n_pass++;
        end
      end
      ack = bus.mem_req && (acc_k == 2);
      drive_mem(ack, 1'b0, ack ? 32'hDEADBEEF : 32'h0BAD0BAD);
      drive_m0((ready_cyc < 0) || (cyc == ready_cyc), 1'b0, 32'h100, '0, 4'hF);
      #1;
      if (bus.stall_m) stall_cnt++;
    end
    clear_inputs();
    n_checks++;
    if (ready_cnt != 1 || m1_cnt != 0)
      $display("FAIL load_pulses: m0 %0d m1 %0d want 1 0", ready_cnt, m1_cnt);
    else n_pass++;
    n_checks++;
    if (ready_cyc + 1 != 4) $display("FAIL load_latency: got %0d cycles want 4", ready_cyc + 1);
    else n_pass++;
    n_checks++;
    if (stall_cnt != 3) $display("FAIL load_stall: got %0d cycles want 3", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_contention();
    int order[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] d, got;
    apply_reset();
    drive_m0(1'b1, 1'b0, 32'h1000, '0, 4'hF);
    drive_m1(1'b1, 1'b0, 32'h2000, '0, 4'hF);
    for (int cyc = 0; cyc < 40 && order.size() < 6; cyc++) begin
      @(negedge clk);
      if (bus.m0_ready || bus.m1_ready) begin
        order.push_back(bus.m1_ready ? 1 : 0);
        got = bus.m1_ready ? bus.m1_rdata : bus.m0_rdata;
        d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if ((bus.m0_ready && bus.m1_ready) || got !== d)
          $display("FAIL rr_resp: ready=%b%b rdata=%h want one-hot %h", bus.m0_ready, bus.m1_ready, got, d);
        else n_pass++;
      end
      if (bus.mem_req) begin
        d = $urandom;
        exp_q.push_back(d);
        drive_mem(1'b1, 1'b0, d);
      end else begin
        drive_mem(1'b0, 1'b0, $urandom);
      end
    end
    clear_inputs();
    n_checks++;
    if (order.size() != 6) $display("FAIL rr_count: got %0d grants want 6", order.size());
    else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++;
      if (order[i] != i % 2) $display("FAIL rr_order[%0d]: got m%0d want m%0d", i, order[i], i % 2);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_err_with_ack();
    int ready_cnt;
    logic seen;
    ready_cnt = 0; seen = 1'b0;
    drive_m1(1'b1, 1'b1, 32'h40, 32'h55, 4'hF);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.m1_ready) begin
        ready_cnt++;
        n_checks++;
        if ({bus.m1_fault, bus.m1_rdata, bus.m0_ready} !== {1'b1, 32'h0, 1'b0})
          $display("FAIL err_resp: fault=%b rdata=%h m0_ready=%b want 1 0 0",
                   bus.m1_fault, bus.m1_rdata, bus.m0_ready);
        else n_pass++;
      end
      if (bus.mem_req && !seen) begin
        seen = 1'b1;
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h40, 32'h55})
          $display("FAIL err_bus: we=%b addr=%h wdata=%h want 1 40 55", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
      end
      drive_mem(bus.mem_req, bus.mem_req, 32'hA5A5A5A5);
      if (ready_cnt > 0 && !bus.m1_ready) drive_m1(1'b0, 1'b0, '0, '0, '0);
    end
    clear_inputs();
    n_checks++;
    if (ready_cnt != 1) $display("FAIL err_pulses: got %0d want 1", ready_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int req_cyc, ready_cnt;
    req_cyc = 0; ready_cnt = 0;
    drive_m0(1'b1, 1'b0, 32'h80, '0, 4'hF);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (bus.mem_req) req_cyc++;
      if (bus.m0_ready) begin
        ready_cnt++;
        n_checks++;
        if ({bus.m0_fault, bus.m0_rdata} !== {1'b1, 32'h0})
          $display("FAIL tmo_resp: fault=%b rdata=%h want 1 0", bus.m0_fault, bus.m0_rdata);
        else n_pass++;
      end
      drive_mem(1'b0, 1'b0, 32'hFFFFFFFF);
      if (ready_cnt > 0 && !bus.m0_ready) drive_m0(1'b0, 1'b0, '0, '0, '0);
    end
    clear_inputs();
    n_checks++;
    if (req_cyc != TIMEOUT) $display("FAIL tmo_req_cycles: got %0d want %0d", req_cyc, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (ready_cnt != 1) $display("FAIL tmo_pulses: got %0d want 1", ready_cnt);
    else n_pass++;
  endtask

  task automatic test_store_fields();
    int acc_k, ready_cnt;
    logic ack;
    acc_k = 0; ready_cnt = 0;
    drive_m0(1'b1, 1'b1, 32'h204, 32'h12345678, 4'b0011);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.m0_ready) begin
        ready_cnt++;
        n_checks++;
        if ({bus.m0_fault, bus.m0_rdata} !== {1'b0, 32'h0})
          $display("FAIL store_resp: fault=%b rdata=%h want 0 0", bus.m0_fault, bus.m0_rdata);
        else n_pass++;
      end
      if (bus.mem_req) begin
        acc_k++;
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 32'h204, 32'h12345678, 4'b0011})
          $display("FAIL store_fields[%0d]: we=%b addr=%h wdata=%h be=%b", acc_k,
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
        else n_pass++;
      end
      ack = bus.mem_req && (acc_k == 3);
      drive_mem(ack, 1'b0, 32'hCAFEF00D);
      if (ready_cnt > 0 && !bus.m0_ready) drive_m0(1'b0, 1'b0, '0, '0, '0);
    end
    clear_inputs();
    n_checks++;
    if (ready_cnt != 1 || acc_k != 3)
      $display("FAIL store_pulses: ready %0d access %0d want 1 3", ready_cnt, acc_k);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int acc_k, first;
    acc_k = 0; first = -1;
    drive_m0(1'b1, 1'b0, 32'h300, '0, 4'hF);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.mem_req) acc_k++;
      if (acc_k == 2) break;
    end
    n_checks++;
    if (bus.mem_req !== 1'b1) $display("FAIL areset_pre: mem_req got %b want 1", bus.mem_req);
    else n_pass++;
    #2 start = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.m0_ready, bus.m1_ready, bus.m0_fault, bus.m1_fault} !== 6'b0)
      $display("FAIL areset_flags: got %b want 000000",
               {bus.mem_req, bus.mem_we, bus.m0_ready, bus.m1_ready, bus.m0_fault, bus.m1_fault});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.m0_rdata, bus.m1_rdata} !== '0)
      $display("FAIL areset_data: mem_addr=%h mem_wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    @(negedge clk);
    start = 1'b1;
    drive_m0(1'b1, 1'b0, 32'h310, '0, 4'hF);
    drive_m1(1'b1, 1'b0, 32'h320, '0, 4'hF);
    for (int cyc = 0; cyc < 10 && first < 0; cyc++) begin
      @(negedge clk);
      if (bus.m0_ready || bus.m1_ready) first = bus.m1_ready ? 1 : 0;
      drive_mem(bus.mem_req, 1'b0, 32'h0);
    end
    clear_inputs();
    n_checks++;
    if (first != 0) $display("FAIL areset_first_grant: got %0d want 0", first);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  // Randomised traffic checked against a transaction-timeline model: each grant
  // occupies 1 + access-length + 1 cycles, the access length being the ack
  // delay + 1 capped at TIMEOUT.
  task automatic test_random(input int n_cycles);
    logic              pend[2];
    logic              t_we[2];
    logic [ADDR_W-1:0] t_addr[2];
    logic [DATA_W-1:0] t_wdata[2];
    logic [BE_W-1:0]   t_be[2];
    logic              rdy_prev[2];
    logic busy, last_win, tmo, exp_fault, exp_r0, exp_r1, in_acc, in_resp;
    int who, g_cyc, lat, kind, acc_len, k, n_done;
    logic [DATA_W-1:0] ack_data, exp_rdata;
    logic [2*DATA_W+1:0] got_v, exp_v;
    apply_reset();
    busy = 1'b0; last_win = 1'b1; tmo = 1'b0; exp_fault = 1'b0;
    who = 0; g_cyc = 0; lat = 0; kind = 0; acc_len = 0; n_done = 0;
    ack_data = '0; exp_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; rdy_prev[m] = 1'b0; t_we[m] = 1'b0;
      t_addr[m] = '0; t_wdata[m] = '0; t_be[m] = '0;
    end
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      in_acc  = busy && (c > g_cyc) && (c <= g_cyc + acc_len);
      in_resp = busy && (c == g_cyc + acc_len + 1);
      exp_r0  = in_resp && (who == 0);
      exp_r1  = in_resp && (who == 1);
      n_checks++;
      if (bus.mem_req !== in_acc) $display("FAIL rnd_mem_req@%0d: got %b want %b", c, bus.mem_req, in_acc);
      else n_pass++;
      n_checks++;
      if ({bus.m0_ready, bus.m1_ready} !== {exp_r0, exp_r1})
        $display("FAIL rnd_ready@%0d: got %b%b want %b%b", c, bus.m0_ready, bus.m1_ready, exp_r0, exp_r1);
      else n_pass++;
      if (in_acc) begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !==
            {t_we[who], t_addr[who], t_wdata[who], t_be[who]})
          $display("FAIL rnd_bus@%0d: addr=%h want %h (m%0d)", c, bus.mem_addr, t_addr[who], who);
        else n_pass++;
      end
      if (in_resp) begin
        got_v = {bus.m0_fault, bus.m0_rdata, bus.m1_fault, bus.m1_rdata};
        exp_v = (who == 0) ? {exp_fault, exp_rdata, 1'b0, {DATA_W{1'b0}}}
                           : {1'b0, {DATA_W{1'b0}}, exp_fault, exp_rdata};
        n_checks++;
        if (got_v !== exp_v) $display("FAIL rnd_resp@%0d: got %h want %h", c, got_v, exp_v);
        else n_pass++;
        busy = 1'b0;
        n_done++;
      end
      // requesters: retire the one served last cycle, maybe start a new access
      for (int m = 0; m < 2; m++) begin
        if (rdy_prev[m]) pend[m] = 1'b0;
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m]    = 1'b1;
          t_we[m]    = 1'($urandom_range(0, 1));
          t_addr[m]  = $urandom;
          t_wdata[m] = $urandom;
          t_be[m]    = BE_W'($urandom_range(0, 15));
        end
      end
      rdy_prev[0] = exp_r0;
      rdy_prev[1] = exp_r1;
      drive_m0(pend[0], t_we[0], t_addr[0], t_wdata[0], t_be[0]);
      drive_m1(pend[1], t_we[1], t_addr[1], t_wdata[1], t_be[1]);
      // arbiter free this cycle: sole requester wins, else the one not served last
      if (!busy && !in_resp && (pend[0] || pend[1])) begin
        who       = (pend[0] && pend[1]) ? (last_win ? 0 : 1) : (pend[1] ? 1 : 0);
        last_win  = (who == 1);
        busy      = 1'b1;
        g_cyc     = c;
        lat       = $urandom_range(0, 5);
        kind      = $urandom_range(0, 3);
        tmo       = (lat + 1 > TIMEOUT);
        acc_len   = tmo ? TIMEOUT : lat + 1;
        ack_data  = $urandom;
        exp_fault = tmo || (kind >= 2);
        exp_rdata = (exp_fault || t_we[who]) ? '0 : ack_data;
      end
      // memory: respond on access cycle lat+1 (0 = ack only, 1 = ack, 2 = err, 3 = err+ack)
      k = c - g_cyc;
      if (busy && !tmo && k == lat + 1) drive_mem(kind != 2, kind >= 2, ack_data);
      else drive_mem(1'b0, 1'b0, $urandom);
      #1;
      n_checks++;
      if (bus.stall_m !== (pend[0] && !exp_r0))
        $display("FAIL rnd_stall@%0d: got %b want %b", c, bus.stall_m, pend[0] && !exp_r0);
      else n_pass++;
    end
    clear_inputs();
    n_checks++;
    if (n_done < 20) $display("FAIL rnd_progress: got %0d completions want >= 20", n_done);
    else n_pass++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    start    = 1'b0;
    clear_inputs();
    test_reset();
    test_single_load();
    test_contention();
    test_err_with_ack();
    test_timeout();
    test_store_fields();
    test_async_reset();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
